// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcode/funct constants, ALU control codes and datapath mux encodings.
package mips_pkg;

    // Controller states, 4-bit encoding. TRAP is only reachable when the
    // design is built with MC_ILLEGAL_TRAP_EN.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    // Operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Datapath mux encodings
    localparam logic       IORD_PC       = 1'b0;
    localparam logic       IORD_ALUOUT   = 1'b1;
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic       ALUA_PC       = 1'b0;
    localparam logic       ALUA_REG      = 1'b1;
    localparam logic [1:0] ALUB_REG      = 2'b00;
    localparam logic [1:0] ALUB_FOUR     = 2'b01;
    localparam logic [1:0] ALUB_IMM      = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2  = 2'b11;
    localparam logic       WA_RT         = 1'b0;
    localparam logic       WA_RD         = 1'b1;
    localparam logic       RES_ALUOUT    = 1'b0;
    localparam logic       RES_MEM       = 1'b1;

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory request/ready channel between the controller and the shared
// instruction/data memory.
//
// Handshake: the controller raises mem_req (with mem_we and sel_iord) and
// holds all three stable until a cycle in which mem_ready=1; the transfer
// completes in that cycle. mem_ready while mem_req=0 carries no meaning.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic sel_iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output sel_iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input sel_iord, output mem_ready);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's operation class and the R-type funct
// field onto the 3-bit alu_ctrl code; funct_valid drops for unsupported functs.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_funct_valid
);

    // Select the ALU operation; unsupported functs fall back to add.
    always_comb begin
        o_alu_ctrl    = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_alu_op)
            ALUOP_ADD: o_alu_ctrl = ALU_ADD;
            ALUOP_SUB: o_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_ctrl = ALU_ADD;
                    FN_SUB:  o_alu_ctrl = ALU_SUB;
                    FN_AND:  o_alu_ctrl = ALU_AND;
                    FN_OR:   o_alu_ctrl = ALU_OR;
                    FN_SLT:  o_alu_ctrl = ALU_SLT;
                    default: o_funct_valid = 1'b0;
                endcase
            end
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving the datapath enables and mux selects.
// Optional build macro: MC_ILLEGAL_TRAP_EN -- illegal opcodes/functs enter a
// sticky TRAP state; without it they retire as a NOP.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [5:0]                     opcode,
    input  logic [5:0]                     funct,
    input  logic                           zero,
    multicycle_controller_if.master        mem,
    output logic                           ir_we,
    output logic                           pc_we,
    output logic [1:0]                     sel_pc_src,
    output logic                           sel_alu_a,
    output logic [1:0]                     sel_alu_b,
    output logic [2:0]                     alu_ctrl,
    output logic                           rf_we,
    output logic                           sel_wa,
    output logic                           sel_result,
    output logic                           retire,
    output logic                           illegal,
    output logic [3:0]                     dbg_state
);

    state_t     r_state;
    state_t     w_next;
    alu_op_t    w_alu_op;
    logic [2:0] w_alu_ctrl;
    logic       w_funct_valid;
    logic       w_illegal_path;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_ir_we;
    logic       w_pc_we;
    logic       w_rf_we;
    logic       w_retire;
    logic       w_sel_iord;
    logic [1:0] w_sel_pc_src;
    logic       w_sel_alu_a;
    logic [1:0] w_sel_alu_b;
    logic       w_sel_wa;
    logic       w_sel_result;

    // ALU operation class depends on state only, keeping the decoder
    // outside the next-state loop.
    always_comb begin
        case (r_state)
            EXEC:    w_alu_op = ALUOP_FUNCT;
            BRANCH:  w_alu_op = ALUOP_SUB;
            default: w_alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (funct),
        .o_alu_ctrl    (w_alu_ctrl),
        .o_funct_valid (w_funct_valid)
    );

    // State register; reset returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs (enables also qualified by mem_ready/zero).
    always_comb begin
        w_next         = r_state;
        w_illegal_path = 1'b0;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_rf_we        = 1'b0;
        w_retire       = 1'b0;
        w_sel_iord     = IORD_PC;
        w_sel_pc_src   = PC_SRC_ALU;
        w_sel_alu_a    = ALUA_PC;
        w_sel_alu_b    = ALUB_REG;
        w_sel_wa       = WA_RT;
        w_sel_result   = RES_ALUOUT;
        case (r_state)
            FETCH: begin
                w_mem_req   = 1'b1;
                w_sel_alu_b = ALUB_FOUR;
                if (mem.mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = DECODE;
                end
            end
            DECODE: begin
                // Branch target PC + (imm<<2) is precomputed into ALUOut.
                w_sel_alu_b = ALUB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXEC;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default:      w_illegal_path = 1'b1;
                endcase
            end
            MEMADR: begin
                w_sel_alu_a = ALUA_REG;
                w_sel_alu_b = ALUB_IMM;
                w_next      = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                w_mem_req  = 1'b1;
                w_sel_iord = IORD_ALUOUT;
                if (mem.mem_ready) begin
                    w_next = MEMWB;
                end
            end
            MEMWB: begin
                w_rf_we      = 1'b1;
                w_sel_wa     = WA_RT;
                w_sel_result = RES_MEM;
                w_retire     = 1'b1;
                w_next       = FETCH;
            end
            MEMWR: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_sel_iord = IORD_ALUOUT;
                if (mem.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = FETCH;
                end
            end
            EXEC: begin
                w_sel_alu_a = ALUA_REG;
                w_sel_alu_b = ALUB_REG;
                if (w_funct_valid) begin
                    w_next = ALUWB;
                end else begin
                    w_illegal_path = 1'b1;
                end
            end
            ALUWB: begin
                w_rf_we      = 1'b1;
                w_sel_wa     = WA_RD;
                w_sel_result = RES_ALUOUT;
                w_retire     = 1'b1;
                w_next       = FETCH;
            end
            BRANCH: begin
                w_sel_alu_a  = ALUA_REG;
                w_sel_alu_b  = ALUB_REG;
                w_sel_pc_src = PC_SRC_ALUOUT;
                w_pc_we      = zero;
                w_retire     = 1'b1;
                w_next       = FETCH;
            end
            ADDIEX: begin
                w_sel_alu_a = ALUA_REG;
                w_sel_alu_b = ALUB_IMM;
                w_next      = ADDIWB;
            end
            ADDIWB: begin
                w_rf_we      = 1'b1;
                w_sel_wa     = WA_RT;
                w_sel_result = RES_ALUOUT;
                w_retire     = 1'b1;
                w_next       = FETCH;
            end
            JUMP: begin
                w_sel_pc_src = PC_SRC_JUMP;
                w_pc_we      = 1'b1;
                w_retire     = 1'b1;
                w_next       = FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP: begin
                w_next = TRAP;
            end
`endif
            default: begin
                w_next = FETCH;
            end
        endcase

        if (w_illegal_path) begin
`ifdef MC_ILLEGAL_TRAP_EN
            w_next = TRAP;
`else
            // Retire as a NOP; PC was already advanced in FETCH.
            w_next   = FETCH;
            w_retire = 1'b1;
`endif
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_next == TRAP) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // Enables are forced low while reset is held, even though the state
    // already sits in FETCH.
    assign mem.mem_req  = w_mem_req & rst_n;
    assign mem.mem_we   = w_mem_we  & rst_n;
    assign mem.sel_iord = w_sel_iord;
    assign ir_we        = w_ir_we   & rst_n;
    assign pc_we        = w_pc_we   & rst_n;
    assign rf_we        = w_rf_we   & rst_n;
    assign retire       = w_retire  & rst_n;
    assign sel_pc_src   = w_sel_pc_src;
    assign sel_alu_a    = w_sel_alu_a;
    assign sel_alu_b    = w_sel_alu_b;
    assign alu_ctrl     = w_alu_ctrl;
    assign sel_wa       = w_sel_wa;
    assign sel_result   = w_sel_result;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Builds the expected per-cycle output
// sequence of each instruction from the instruction-level timing rules and
// compares it cycle by cycle. Honours MC_ILLEGAL_TRAP_EN like the design.
module tb_multicycle_controller;
    import mips_pkg::*;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       ir_we, pc_we, sel_alu_a, rf_we, sel_wa, sel_result, retire, illegal;
    logic [1:0] sel_pc_src, sel_alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [21:0] exp_q[$];
    logic        rdy_q[$];

    multicycle_controller_if mif ();

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem        (mif),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .sel_pc_src (sel_pc_src),
        .sel_alu_a  (sel_alu_a),
        .sel_alu_b  (sel_alu_b),
        .alu_ctrl   (alu_ctrl),
        .rf_we      (rf_we),
        .sel_wa     (sel_wa),
        .sel_result (sel_result),
        .retire     (retire),
        .illegal    (illegal),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Output vector: {req,we,iord,ir_we,pc_we,pc_src,alu_a,alu_b,alu_ctrl,rf_we,wa,result,retire,illegal}
    function automatic logic [17:0] o(input logic req, input logic we, input logic iord,
                                      input logic irwe, input logic pcwe, input logic [1:0] pcsrc,
                                      input logic alua, input logic [1:0] alub, input logic [2:0] aluc,
                                      input logic rfwe, input logic wa, input logic res,
                                      input logic ret, input logic ill);
        return {req, we, iord, irwe, pcwe, pcsrc, alua, alub, aluc, rfwe, wa, res, ret, ill};
    endfunction

    function automatic logic [21:0] obs();
        return {dbg_state, mif.mem_req, mif.mem_we, mif.sel_iord, ir_we, pc_we, sel_pc_src,
                sel_alu_a, sel_alu_b, alu_ctrl, rf_we, sel_wa, sel_result, retire, illegal};
    endfunction

    function automatic bit op_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    endfunction

    // Reference funct -> alu_ctrl mapping (standard MIPS functs).
    function automatic logic [3:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, 3'b010};
            6'b100010: return {1'b1, 3'b110};
            6'b100100: return {1'b1, 3'b000};
            6'b100101: return {1'b1, 3'b001};
            6'b101010: return {1'b1, 3'b111};
            default:   return {1'b0, 3'b010};
        endcase
    endfunction

    task automatic add(input state_t st, input logic [17:0] v, input logic rdy);
        exp_q.push_back({st, v});
        rdy_q.push_back(rdy);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle sequence for one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fst,
                         input int mst, input logic z);
        logic [3:0] a;
        bit         nop;
        for (int i = 0; i < fst; i++)
            add(FETCH, o(1,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0,0), 1'b0);
        add(FETCH, o(1,0,0,1,1,2'b00,0,2'b01,3'b010,0,0,0,0,0), 1'b1);
        nop = !op_legal(op);
        add(DECODE, o(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,nop && !TRAP_EN,0), rnd());
        if (op == 6'b100011 || op == 6'b101011)
            add(MEMADR, o(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0,0), rnd());
        if (op == 6'b100011) begin
            for (int i = 0; i < mst; i++)
                add(MEMRD, o(1,0,1,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0), 1'b0);
            add(MEMRD, o(1,0,1,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0), 1'b1);
            add(MEMWB, o(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,0,1,1,0), rnd());
        end else if (op == 6'b101011) begin
            for (int i = 0; i < mst; i++)
                add(MEMWR, o(1,1,1,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0), 1'b0);
            add(MEMWR, o(1,1,1,0,0,2'b00,0,2'b00,3'b010,0,0,0,1,0), 1'b1);
        end else if (op == 6'b000000) begin
            a = ref_alu(fn);
            add(EXEC, o(0,0,0,0,0,2'b00,1,2'b00,a[2:0],0,0,0,!a[3] && !TRAP_EN,0), rnd());
            if (a[3])
                add(ALUWB, o(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,1,0,1,0), rnd());
            else
                nop = 1'b1;
        end else if (op == 6'b000100) begin
            add(BRANCH, o(0,0,0,0,z,2'b01,1,2'b00,3'b110,0,0,0,1,0), rnd());
        end else if (op == 6'b001000) begin
            add(ADDIEX, o(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0,0), rnd());
            add(ADDIWB, o(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,0,0,1,0), rnd());
        end else if (op == 6'b000010) begin
            add(JUMP, o(0,0,0,0,1,2'b10,0,2'b00,3'b010,0,0,0,1,0), rnd());
        end
        if (nop && TRAP_EN)
            for (int i = 0; i < 20; i++)
                add(TRAP, o(0,0,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,1), rnd());
    endtask

    task automatic check(input string tag, input int cyc, input logic [21:0] exp);
        logic [21:0] got;
        got = obs();
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Replay the expected queue; instruction fields are applied in FETCH.
    task automatic play(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                opcode = op;
                funct  = fn;
                zero   = z;
            end
            mif.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            check(tag, cyc, exp_q.pop_front());
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input int fst, input int mst, input logic z);
        build(op, fn, fst, mst, z);
        play(tag, op, fn, z);
    endtask

    initial begin
        logic [17:0] rst_v;
        logic [5:0]  op_tab[7];
        logic [5:0]  fn_tab[5];
        logic [5:0]  bad_tab[4];
        logic [5:0]  op, fn;
        op_tab  = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bad_tab = '{6'b111111, 6'b000001, 6'b010000, 6'b100000};
        rst_v   = o(0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0,0);

        // Reset held with mem_ready high
        mif.mem_ready = 1'b1;
        #2;
        check("reset_hold", 0, {FETCH, rst_v});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_fetch", 0, {FETCH, o(1,0,0,1,1,2'b00,0,2'b01,3'b010,0,0,0,0,0)});
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_fetch", 0, {FETCH, rst_v});
        @(negedge clk);
        mif.mem_ready = 1'b0;
        rst_n = 1'b1;

        // Directed instructions
        run("lw", 6'b100011, 6'd0, 0, 0, 1'b0);
        run("sw_stall3", 6'b101011, 6'd0, 0, 3, 1'b0);
        run("lw_stalls", 6'b100011, 6'd0, 2, 2, 1'b1);
        run("beq_taken", 6'b000100, 6'd0, 0, 0, 1'b1);
        run("beq_not_taken", 6'b000100, 6'd0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++)
            run("rtype", 6'b000000, fn_tab[i], 0, 0, 1'b0);
        run("addi", 6'b001000, 6'd0, 1, 0, 1'b0);
        run("jump", 6'b000010, 6'd0, 0, 0, 1'b1);
        if (!TRAP_EN) begin
            run("illegal_nop", 6'b111111, 6'd0, 0, 0, 1'b0);
            run("bad_funct_nop", 6'b000000, 6'b000111, 0, 0, 1'b0);
        end

        // Reset in the middle of a load's memory read
        @(posedge clk);
        #1;
        opcode = 6'b100011;
        mif.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        check("memrd_before_reset", 0, {MEMRD, o(1,0,1,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0)});
        rst_n = 1'b0;
        #1;
        check("reset_mid_memrd", 0, {FETCH, rst_v});
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            op = op_tab[$urandom_range(0, TRAP_EN ? 5 : 6)];
            if (op == 6'b111111)
                op = bad_tab[$urandom_range(0, 3)];
            if (TRAP_EN || $urandom_range(0, 3) != 0)
                fn = fn_tab[$urandom_range(0, 4)];
            else
                fn = 6'($urandom_range(0, 63));
            run("random", op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
        end

`ifdef MC_ILLEGAL_TRAP_EN
        // Illegal opcode traps and holds until reset
        run("trap", 6'b111111, 6'd0, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("trap_reset", 0, {FETCH, rst_v});
        @(negedge clk);
        mif.mem_ready = 1'b0;
        rst_n = 1'b1;
        run("after_trap", 6'b000010, 6'd0, 0, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback, driving register enables and mux selects each cycle. It sits beside the shared instruction/data memory, ALU, register file and IR/PC registers, replacing single-cycle decoding. Memory accesses use a request/ready handshake, so the controller stalls on slow memory. It supports the instructions R-type (ADD/SUB/AND/OR/SLT), LW, SW, BEQ, ADDI and J.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid with mem_req)
- sel_iord  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  load PC
- sel_pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- sel_alu_a  out  1  0 = PC, 1 = register A
- sel_alu_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- rf_we  out  1  register file write
- sel_wa  out  1  write address: 0 = rt, 1 = rd
- sel_result  out  1  writeback data: 0 = ALUOut, 1 = memory data register
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky trap flag (see Configuration)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP. Encoded in 4 bits.
- Outputs not listed for a state are 0, except alu_ctrl, which is 010.
- FETCH: mem_req=1, sel_iord=0, sel_alu_a=0, sel_alu_b=01, sel_pc_src=00.
  - ir_we and pc_we are asserted only when mem_ready=1.
  - On mem_ready, go to DECODE; otherwise hold.
- DECODE: sel_alu_a=0, sel_alu_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - otherwise → illegal path
- MEMADR: sel_alu_a=1, sel_alu_b=10, add. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, sel_iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: rf_we=1, sel_wa=0, sel_result=1, retire=1. Go to FETCH.
- MEMWR: mem_req=1, mem_we=1, sel_iord=1. On mem_ready, retire=1 and go to FETCH; otherwise hold.
- EXEC: sel_alu_a=1, sel_alu_b=00, alu_ctrl from funct. Unsupported funct → illegal path; otherwise → ALUWB.
- ALUWB: rf_we=1, sel_wa=1, sel_result=0, retire=1. Go to FETCH.
- BRANCH: sel_alu_a=1, sel_alu_b=00, sub, sel_pc_src=01, pc_we=zero, retire=1. Go to FETCH.
- ADDIEX: sel_alu_a=1, sel_alu_b=10, add. Go to ADDIWB.
- ADDIWB: rf_we=1, sel_wa=0, sel_result=0, retire=1. Go to FETCH.
- JUMP: sel_pc_src=10, pc_we=1, retire=1. Go to FETCH.

## Timing
- Reset (asynchronous): state=FETCH, illegal=0.
  - While rst_n=0, mem_req, mem_we, ir_we, pc_we, rf_we and retire are all 0.
  - Mux selects take their FETCH values.
- Reset asserted mid-instruction aborts immediately; no enable stays high after rst_n falls.
- Memory handshake:
  - mem_req stays high and the address select stays stable until the cycle mem_ready=1; the transfer completes in that cycle.
  - mem_ready while mem_req=0 is ignored.
- Cycles per instruction with mem_ready tied to 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
- Each cycle mem_ready=0 during a memory state adds 1 cycle.
- All outputs are combinational from state, plus mem_ready/zero/funct where stated. The next state registers on the clk rising edge.

## Configuration
- MC_ILLEGAL_TRAP_EN defined:
  - The illegal path goes to TRAP and sets illegal=1.
  - TRAP holds forever with all enables 0 and no retire; only reset exits it.
- MC_ILLEGAL_TRAP_EN undefined:
  - The illegal path goes to FETCH with retire=1, so the instruction behaves as a NOP and PC is already advanced.
  - illegal is tied to 0 and the TRAP state is not built.

## Structure
- Shared package mips_pkg holds:
  - the state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALU_ADD/SUB/AND/OR/SLT alu_ctrl codes
  - the mux-select encodings
- One sub-module, alu_decoder, maps (alu_op, funct) to alu_ctrl plus a funct_valid flag.

## Test plan
- Reset mid-FETCH with mem_ready=1: all write enables drop within the same cycle. After release, the first FETCH asserts ir_we=pc_we=1.
- LW (opcode 100011), mem_ready=1: states FETCH→DECODE→MEMADR→MEMRD→MEMWB. retire is high in cycle 5 only, with rf_we=1, sel_result=1, sel_wa=0.
- SW with mem_ready low 3 cycles in MEMWR: mem_req=mem_we=sel_iord=1 held for 4 cycles, retire on the 4th, total 7 cycles.
- BEQ: with zero=1, pc_we=1 and sel_pc_src=01 in cycle 3; with zero=0, pc_we=0. Both cases retire.
- R-type funct 101010: alu_ctrl=111 in EXEC, then ALUWB with sel_wa=1. Repeat for ADD/SUB/AND/OR giving 010/110/000/001.
- Opcode 111111:
  - with MC_ILLEGAL_TRAP_EN: illegal=1 and the FSM stays in TRAP for 20 cycles with no enables.
  - without it: retire after DECODE and the next FETCH starts.
